// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register: operation modes, FSM states
// and small mode-classification helpers.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_CLR  = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Shift and rotate modes run over several cycles; the rest finish at once
    function automatic logic is_multi_step(input logic [2:0] mode);
        logic res;
        case (mode)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: res = 1'b1;
            default:                                           res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic sout_from_msb(input logic [2:0] mode);
        logic res;
        case (mode)
            MODE_SHL, MODE_ROL: res = 1'b1;
            default:            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register; the requester drives
// the master side, the register implements the slave side.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
) ();

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             en;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output en, start, mode, amount, d, sin,
        input  q, sout, busy, done
    );

    modport slave (
        input  en, start, mode, amount, d, sin,
        output q, sout, busy, done
    );

endinterface

// File: rtl/shift_step.sv
// Single-bit step of every shift/rotate mode; non-shift modes pass q through.
module shift_step
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             sin,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] q_next
);

    // One step of the selected operation
    always_comb begin
        q_next = q;
        case (mode)
            MODE_SHL: q_next = {q[WIDTH-2:0], sin};
            MODE_SHR: q_next = {sin, q[WIDTH-1:1]};
            MODE_ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR: q_next = {q[0], q[WIDTH-1:1]};
            MODE_ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:  q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-cycle LOAD/CLR/HOLD plus multi-cycle
// shift/rotate operations sequenced by an IDLE/RUN/DONE controller.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    univ_shift_reg_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] RUN  = 2'(ST_RUN);
    localparam logic [1:0] DONE = 2'(ST_DONE);

    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       state_r;
    logic [2:0]       mode_r;
    logic             busy_r;
    logic             done_r;
    logic             sout_r;

    logic [WIDTH-1:0] q_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       state_nxt_s;
    logic [2:0]       mode_nxt_s;
    logic [WIDTH-1:0] step_q_s;
    logic             sout_nxt_s;

    // Steps always use the latched mode; sin is taken live from the bus
    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (q_r),
        .sin    (bus.sin),
        .mode   (mode_r),
        .q_next (step_q_s)
    );

    // Next-state, next-data and counter decode
    always_comb begin
        q_nxt_s     = q_r;
        cnt_nxt_s   = cnt_r;
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        if (!bus.en) begin
            state_nxt_s = state_r;
        end else if (state_r == RUN) begin
            q_nxt_s = step_q_s;
            // A zero count cannot occur in RUN; treat it as finished rather than wrap
            if (cnt_r <= CNT_W'(1)) begin
                cnt_nxt_s   = {CNT_W{1'b0}};
                state_nxt_s = DONE;
            end else begin
                cnt_nxt_s   = cnt_r - CNT_W'(1);
                state_nxt_s = RUN;
            end
        end else if (bus.start) begin
            mode_nxt_s = bus.mode;
            if (is_multi_step(bus.mode)) begin
                cnt_nxt_s = bus.amount;
                if (bus.amount != {CNT_W{1'b0}}) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = DONE;
                end
            end else begin
                state_nxt_s = DONE;
                case (bus.mode)
                    MODE_LOAD: q_nxt_s = bus.d;
                    MODE_CLR:  q_nxt_s = {WIDTH{1'b0}};
                    default:   q_nxt_s = q_r;
                endcase
            end
        end else if (state_r == DONE) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Serial output tracks the bit that the latched mode will push out next
    always_comb begin
        if (sout_from_msb(mode_nxt_s)) begin
            sout_nxt_s = q_nxt_s[WIDTH-1];
        end else begin
            sout_nxt_s = q_nxt_s[0];
        end
    end

    // State, data and registered status update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= IDLE;
            mode_r  <= 3'(MODE_HOLD);
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sout_r  <= 1'b0;
        end else begin
            q_r     <= q_nxt_s;
            cnt_r   <= cnt_nxt_s;
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
            sout_r  <= sout_nxt_s;
        end
    end

    assign bus.q    = q_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sout = sout_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed scenarios plus
// randomized operations compared against an arithmetic reference model.
module tb_univ_shift_reg;
    import univ_shift_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int MODV  = 1 << WIDTH;
    localparam int TOPB  = 1 << (WIDTH - 1);

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    univ_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: one step expressed as integer arithmetic on the value
    function automatic logic [WIDTH-1:0] ref_step(input logic [WIDTH-1:0] v,
                                                  input logic [2:0] m, input logic s);
        int u;
        u = int'(v);
        case (m)
            MODE_SHL: u = (u * 2 + (s ? 1 : 0)) % MODV;
            MODE_SHR: u = u / 2 + (s ? TOPB : 0);
            MODE_ROL: u = (u * 2) % MODV + u / TOPB;
            MODE_ROR: u = u / 2 + (u % 2) * TOPB;
            MODE_ASR: u = u / 2 + ((u >= TOPB) ? TOPB : 0);
            default:  u = u;
        endcase
        return WIDTH'(u);
    endfunction

    function automatic logic ref_sout(input logic [WIDTH-1:0] v, input logic [2:0] m);
        return (m == MODE_SHL || m == MODE_ROL) ? v[WIDTH-1] : v[0];
    endfunction

    task automatic do_load(input logic [WIDTH-1:0] val);
        bus.en = 1'b1; bus.start = 1'b1; bus.mode = MODE_LOAD; bus.d = val;
        tick();
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q: got %02h want 00", bus.q); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.sout !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b want 0", bus.sout); end
    endtask

    task automatic test_load();
        bus.en = 1'b1; bus.start = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'hA5;
        tick();
        bus.start = 1'b0; bus.d = 8'h00;
        checks++; if (bus.q !== 8'hA5) begin errors++; $display("FAIL load_q: got %02h want a5", bus.q); end
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL load_status: got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy); end
        tick();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'hA5) begin errors++; $display("FAIL load_after: got done=%b busy=%b q=%02h want 0 0 a5", bus.done, bus.busy, bus.q); end
    endtask

    task automatic test_shl();
        logic [WIDTH-1:0] exp_q [3];
        exp_q[0] = 8'h4B; exp_q[1] = 8'h97; exp_q[2] = 8'h2F;
        bus.start = 1'b1; bus.mode = MODE_SHL; bus.amount = 4'd3; bus.sin = 1'b1;
        tick();
        bus.start = 1'b0; bus.mode = MODE_CLR; bus.amount = 4'd1; bus.d = 8'hFF;
        checks++; if (bus.q !== 8'hA5 || bus.busy !== 1'b1) begin errors++; $display("FAIL shl_start: got q=%02h busy=%b want a5 1", bus.q, bus.busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.q !== exp_q[i]) begin errors++; $display("FAIL shl_step%0d: got %02h want %02h", i, bus.q, exp_q[i]); end
            checks++; if (bus.busy !== (i < 2) || bus.done !== (i == 2)) begin errors++; $display("FAIL shl_status%0d: got busy=%b done=%b want %b %b", i, bus.busy, bus.done, (i < 2), (i == 2)); end
        end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL shl_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_asr();
        do_load(8'h90);
        bus.start = 1'b1; bus.mode = MODE_ASR; bus.amount = 4'd2;
        tick();
        bus.start = 1'b0;
        tick();
        checks++; if (bus.q !== 8'hC8) begin errors++; $display("FAIL asr_step0: got %02h want c8", bus.q); end
        tick();
        checks++; if (bus.q !== 8'hE4 || bus.done !== 1'b1) begin errors++; $display("FAIL asr_step1: got q=%02h done=%b want e4 1", bus.q, bus.done); end
        checks++; if (bus.sout !== 1'b0) begin errors++; $display("FAIL asr_sout: got %b want 0", bus.sout); end
        tick();
    endtask

    task automatic test_ror_stall();
        int busy_n;
        int cyc;
        do_load(8'hA5);
        bus.start = 1'b1; bus.mode = MODE_ROR; bus.amount = 4'd8;
        tick();
        bus.start = 1'b0;
        busy_n = 0; cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy === 1'b1) busy_n++;
            bus.en = (cyc == 3 || cyc == 4) ? 1'b0 : 1'b1;
            tick();
            cyc++;
        end
        bus.en = 1'b1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ror_timeout: got done=%b want 1 within 40 cycles", bus.done); end
        checks++; if (busy_n != 10) begin errors++; $display("FAIL ror_busy_cycles: got %0d want 10", busy_n); end
        checks++; if (bus.q !== 8'hA5) begin errors++; $display("FAIL ror_q: got %02h want a5", bus.q); end
        bus.en = 1'b0;
        tick();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_stall: got %b want 1", bus.done); end
        bus.en = 1'b1;
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_release: got %b want 0", bus.done); end
    endtask

    task automatic test_zero_amount();
        bus.start = 1'b1; bus.mode = MODE_SHR; bus.amount = 4'd0; bus.sin = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 8'hA5) begin errors++; $display("FAIL zero_amount: got done=%b busy=%b q=%02h want 1 0 a5", bus.done, bus.busy, bus.q); end
        tick();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b busy=%b want 0 0", bus.done, bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        do_load(8'h81);
        bus.start = 1'b1; bus.mode = MODE_ROL; bus.amount = 4'd5;
        tick();
        bus.start = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sout !== 1'b0) begin errors++; $display("FAIL async_reset: got q=%02h busy=%b done=%b sout=%b want 00 0 0 0", bus.q, bus.busy, bus.done, bus.sout); end
        tick();
        reset_n = 1'b1;
        bus.start = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'h3C;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.q !== 8'h3C || bus.done !== 1'b1) begin errors++; $display("FAIL reload_after_reset: got q=%02h done=%b want 3c 1", bus.q, bus.done); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.start = 1'b1; bus.mode = MODE_LOAD; bus.d = 8'h5A;
        tick();
        bus.mode = MODE_ROL; bus.amount = 4'd1;
        checks++; if (bus.q !== 8'h5A || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_load: got q=%02h done=%b want 5a 1", bus.q, bus.done); end
        tick();
        bus.start = 1'b0;
        checks++; if (bus.q !== 8'h5A || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got q=%02h busy=%b want 5a 1", bus.q, bus.busy); end
        tick();
        checks++; if (bus.q !== 8'hB4 || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_rol: got q=%02h done=%b want b4 1", bus.q, bus.done); end
        tick();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] mq;
        logic [2:0]       mmode;
        int               rem;
        int               phase; // 0 idle, 1 running, 2 done
        mq = 8'($urandom);
        do_load(mq);
        for (int k = 0; k < 30; k++) begin
            mmode = 3'(2 + $urandom_range(0, 4));
            rem   = $urandom_range(0, 15);
            bus.en = 1'b1; bus.start = 1'b1; bus.mode = mmode; bus.amount = CNT_W'(rem);
            bus.d = 8'($urandom); bus.sin = 1'($urandom);
            tick();
            bus.start = 1'b0;
            phase = (rem != 0) ? 1 : 2;
            for (int c = 0; c < 80 && phase != 0; c++) begin
                checks++;
                if (bus.q !== mq || bus.busy !== (phase == 1) || bus.done !== (phase == 2) || bus.sout !== ref_sout(mq, mmode)) begin
                    errors++;
                    $display("FAIL rand_op%0d_cyc%0d: got q=%02h busy=%b done=%b sout=%b want q=%02h busy=%b done=%b sout=%b",
                             k, c, bus.q, bus.busy, bus.done, bus.sout, mq, (phase == 1), (phase == 2), ref_sout(mq, mmode));
                end
                bus.en     = ($urandom_range(0, 3) != 0);
                bus.sin    = 1'($urandom);
                bus.mode   = 3'($urandom);
                bus.amount = CNT_W'($urandom);
                bus.d      = 8'($urandom);
                bus.start  = (phase == 1) ? 1'($urandom) : 1'b0;
                tick();
                if (bus.en) begin
                    if (phase == 1) begin
                        mq = ref_step(mq, mmode, bus.sin);
                        rem--;
                        if (rem == 0) phase = 2;
                    end else begin
                        phase = 0;
                    end
                end
            end
            bus.start = 1'b0; bus.en = 1'b1;
            checks++;
            if (phase != 0 || bus.q !== mq || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL rand_end%0d: got q=%02h busy=%b done=%b want q=%02h busy=0 done=0 (model phase %0d)",
                         k, bus.q, bus.busy, bus.done, mq, phase);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.en = 1'b0; bus.start = 1'b0; bus.mode = MODE_HOLD;
        bus.amount = 4'd0; bus.d = 8'h00; bus.sin = 1'b0;
        #3;
        test_reset();
        tick();
        tick();
        reset_n = 1'b1;
        test_load();
        test_shl();
        test_asr();
        test_ror_stall();
        test_zero_amount();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, is the data width in bits and SHALL be at least 2.
REQ-002 Derived localparam CNT_W = $clog2(WIDTH)+1 SHALL be the width of the shift-amount and counter fields.
REQ-003 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1, is the asynchronous, active-low reset.
REQ-005 Port en, input, 1, is the global enable; when low, all state SHALL hold.
REQ-006 Port start, input, 1, requests an operation.
REQ-007 Port mode, input, 3, selects the operation: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR.
REQ-008 Port amount, input, CNT_W, is the number of single-bit steps for shift and rotate modes.
REQ-009 Port d, input, WIDTH, is the parallel load data.
REQ-010 Port sin, input, 1, is the serial fill bit for SHL and SHR.
REQ-011 Port q, output, WIDTH, is the registered contents.
REQ-012 Port sout, output, 1, is the next bit to leave the register: q[WIDTH-1] for SHL/ROL, otherwise q[0], selected by the latched mode.
REQ-013 Port busy, output, 1, SHALL be high while a multi-step operation runs.
REQ-014 Port done, output, 1, SHALL be a one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE).
REQ-016 start SHALL be accepted only in IDLE or DONE with en high; in RUN it SHALL be ignored.
REQ-017 On accepted start with LOAD, CLR or HOLD, q SHALL become d, 0 or unchanged respectively at that edge, and the FSM SHALL go to DONE.
REQ-018 On accepted start with a shift or rotate mode:
- mode and amount SHALL be latched;
- q SHALL NOT change at that edge;
- the FSM SHALL go to RUN if amount is nonzero, or to DONE if amount is 0.
REQ-019 In RUN with en high, each edge SHALL perform one step:
- SHL: q={q[W-2:0],sin}
- SHR: q={sin,q[W-1:1]}
- ROL, ROR: rotate by 1
- ASR: q={q[W-1],q[W-1:1]}
REQ-020 Each step in RUN SHALL decrement the counter; the step that brings it to 0 SHALL move the FSM to DONE.
REQ-021 amount=N SHALL give exactly N busy cycles (en high throughout) and done in cycle N+1 after the start edge.
REQ-022 amount values above WIDTH SHALL be honoured literally; they are not saturated.
REQ-023 During RUN, changes on mode, amount and d SHALL be ignored; sin SHALL be sampled live at each step.
REQ-024 en low SHALL freeze q, the counter and the state, and extend busy or done by the stalled cycles.
REQ-025 DONE SHALL last one enabled cycle, then go to IDLE, unless a start is accepted in that cycle.

Reset
REQ-026 reset_n low SHALL immediately force q=0, counter=0, state=IDLE, busy=0, done=0 and sout=0, including in the middle of an operation.
REQ-027 The first edge after reset_n rises SHALL be able to accept start.

Structure
REQ-028 Package univ_shift_pkg SHALL hold the mode enum and the FSM state enum.
REQ-029 A combinational sub-module shift_step (inputs q, sin, mode; output next q) SHALL implement the single step.

Verification (WIDTH=8)
REQ-030 LOAD, d=8'hA5, start one cycle -> q=8'hA5 at the next edge; done high for 1 cycle; busy never high.
REQ-031 q=8'hA5, SHL, amount=3, sin=1 -> q steps 4B, 97, 2F; busy high 3 cycles; done in cycle 4.
REQ-032 q=8'h90, ASR, amount=2 -> q=C8 then E4; sout=0 at the end.
REQ-033 q=8'hA5, ROR, amount=8, en low for 2 cycles mid-run -> busy high 10 cycles; final q=8'hA5.
REQ-034 SHR, amount=0 -> done the next cycle; q unchanged; busy never high.
REQ-035 reset_n pulsed low during RUN of a ROL, amount=5 -> q=00 and busy=0 asynchronously; a new LOAD 8'h3C succeeds on the first edge after release.
